// File: rtl/io_pinmux_wb_if.sv
// Wishbone slave bundle for the pad multiplexer's register port.
interface io_pinmux_wb_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/io_pinmux_wb.sv
// Wishbone-programmable pad multiplexer: per-pad function select, optional
// 2-flop input synchroniser and a sticky configuration lock.
module io_pinmux_wb #(
    parameter int          N_PADS       = 37,
    parameter int          N_FUNCS      = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          DEFAULT_FUNC = 0
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    io_pinmux_wb_if.slave               wb,
    input  logic [N_PADS*N_FUNCS-1:0]   periph_out_i,
    input  logic [N_PADS*N_FUNCS-1:0]   periph_oe_i,
    output logic [N_PADS*N_FUNCS-1:0]   periph_in_o,
    input  logic [N_PADS-1:0]           io_in,
    output logic [N_PADS-1:0]           io_out,
    output logic [N_PADS-1:0]           io_oeb
);
    localparam logic [1:0] DEF_SEL = 2'(DEFAULT_FUNC);
    localparam logic [2:0] NF      = 3'(N_FUNCS);

    logic [2*N_PADS-1:0] sel_q, sel_d;
    logic [N_PADS-1:0]   sync_q, sync_d;
    logic [N_PADS-1:0]   meta_q, sync2_q, pad_in;
    logic                lock_q, lock_d;
    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;

    logic [127:0]        sel_all, sel_wr;
    logic [63:0]         sync_all, sync_wr;
    logic [31:0]         wmask, rd_word, merged;
    logic [5:0]          word;
    logic                hit, req, wr_en, is_sel, is_sync, is_lock;
    logic                unused_bits;

    assign word    = wb.wbs_adr_i[7:2];
    assign hit     = wb.wbs_adr_i[31:8] == BASE_ADDR[31:8];
    assign req     = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q;
    assign wr_en   = req & wb.wbs_we_i & hit;
    assign is_sel  = word[5:2] == 4'd0;
    assign is_sync = word[5:1] == 5'd4;
    assign is_lock = word == 6'd12;
    assign wmask   = {{8{wb.wbs_sel_i[3]}}, {8{wb.wbs_sel_i[2]}},
                      {8{wb.wbs_sel_i[1]}}, {8{wb.wbs_sel_i[0]}}};

    // Zero-padded views make bits of non-existent pads read 0 and drop writes.
    always_comb begin
        sel_all                   = '0;
        sel_all[2*N_PADS-1:0]     = sel_q;
        sync_all                  = '0;
        sync_all[N_PADS-1:0]      = sync_q;
    end

    always_comb begin
        rd_word = '0;
        if (hit) begin
            if (is_sel)
                rd_word = sel_all[{word[1:0], 5'd0} +: 32];
            else if (is_sync)
                rd_word = sync_all[{word[0], 5'd0} +: 32];
            else if (is_lock)
                rd_word = {31'd0, lock_q};
        end
    end

    assign merged = (rd_word & ~wmask) | (wb.wbs_dat_i & wmask);

    always_comb begin
        sel_wr  = sel_all;
        sync_wr = sync_all;
        lock_d  = lock_q;
        if (wr_en && !lock_q && is_sel)
            sel_wr[{word[1:0], 5'd0} +: 32] = merged;
        if (wr_en && !lock_q && is_sync)
            sync_wr[{word[0], 5'd0} +: 32] = merged;
        if (wr_en && is_lock && wmask[0] && wb.wbs_dat_i[0])
            lock_d = 1'b1;
        sel_d  = sel_wr[2*N_PADS-1:0];
        sync_d = sync_wr[N_PADS-1:0];
    end

    assign ack_d = req;
    assign dat_d = (req && !wb.wbs_we_i) ? rd_word : 32'd0;

    assign unused_bits = ^{wb.wbs_adr_i[1:0], sel_wr, sync_wr};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sel_q   <= {N_PADS{DEF_SEL}};
            sync_q  <= '1;
            lock_q  <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            meta_q  <= '0;
            sync2_q <= '0;
        end else begin
            sel_q   <= sel_d;
            sync_q  <= sync_d;
            lock_q  <= lock_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            meta_q  <= io_in;
            sync2_q <= meta_q;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;

    assign pad_in = (sync_q & sync2_q) | (~sync_q & io_in);

    for (genvar p = 0; p < N_PADS; p++) begin : g_pad
        logic [1:0] s;
        logic       en;
        logic [3:0] outs, oes;

        assign s  = sel_q[2*p +: 2];
        assign en = {1'b0, s} < NF;

        always_comb begin
            outs                = '0;
            oes                 = '0;
            outs[N_FUNCS-1:0]   = periph_out_i[p*N_FUNCS +: N_FUNCS];
            oes[N_FUNCS-1:0]    = periph_oe_i[p*N_FUNCS +: N_FUNCS];
        end

        assign io_out[p] = en & outs[s];
        assign io_oeb[p] = ~(en & oes[s]);

        // A select >= N_FUNCS matches no channel, so a disabled pad feeds all zeros.
        for (genvar f = 0; f < N_FUNCS; f++) begin : g_func
            assign periph_in_o[p*N_FUNCS + f] = pad_in[p] & (s == 2'(f));
        end
    end
endmodule

// File: tb/tb_io_pinmux_wb.sv
// Randomised bench for io_pinmux_wb against a register/pad reference model.
`timescale 1ns/1ps
module tb_io_pinmux_wb;
    localparam int          NP   = 37;
    localparam int          NF   = 4;
    localparam int          SNP  = 8;
    localparam int          SNF  = 3;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] adr = 32'd0, dat = 32'd0;
    int          tgt = 0;

    io_pinmux_wb_if bus0();
    io_pinmux_wb_if bus1();

    assign bus0.wbs_stb_i = stb & (tgt == 0);
    assign bus0.wbs_cyc_i = cyc & (tgt == 0);
    assign bus0.wbs_we_i  = we;
    assign bus0.wbs_sel_i = sel;
    assign bus0.wbs_adr_i = adr;
    assign bus0.wbs_dat_i = dat;
    assign bus1.wbs_stb_i = stb & (tgt == 1);
    assign bus1.wbs_cyc_i = cyc & (tgt == 1);
    assign bus1.wbs_we_i  = we;
    assign bus1.wbs_sel_i = sel;
    assign bus1.wbs_adr_i = adr;
    assign bus1.wbs_dat_i = dat;

    logic        ack_w;
    logic [31:0] dat_w;
    assign ack_w = (tgt == 0) ? bus0.wbs_ack_o : bus1.wbs_ack_o;
    assign dat_w = (tgt == 0) ? bus0.wbs_dat_o : bus1.wbs_dat_o;

    logic [NP*NF-1:0]   p_out = '0, p_oe = '0, p_in;
    logic [NP-1:0]      io_in = '0, io_out, io_oeb;
    logic [SNP*SNF-1:0] s_out = '0, s_oe = '0, s_pin;
    logic [SNP-1:0]     s_io_in = '0, s_io_out, s_io_oeb;

    io_pinmux_wb #(.N_PADS(NP), .N_FUNCS(NF)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus0),
        .periph_out_i(p_out), .periph_oe_i(p_oe), .periph_in_o(p_in),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb)
    );

    io_pinmux_wb #(.N_PADS(SNP), .N_FUNCS(SNF)) dut3 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus1),
        .periph_out_i(s_out), .periph_oe_i(s_oe), .periph_in_o(s_pin),
        .io_in(s_io_in), .io_out(s_io_out), .io_oeb(s_io_oeb)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model of the register file (main instance only).
    logic [1:0] m_sel  [NP];
    logic       m_sync [NP];
    logic       m_lock;

    function automatic void m_reset();
        for (int p = 0; p < NP; p++) begin
            m_sel[p]  = 2'd0;
            m_sync[p] = 1'b1;
        end
        m_lock = 1'b0;
    endfunction

    function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        int off;
        if (a[31:8] != BASE[31:8]) return;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
        off = int'(a[7:0]) & 'hFC;
        if (off == 'h30 && mask[0] && d[0]) m_lock = 1'b1;
        if (m_lock) return;
        for (int p = 0; p < NP; p++) begin
            if (off == 4 * (p / 16))
                for (int k = 0; k < 2; k++)
                    if (mask[2*(p%16)+k]) m_sel[p][k] = d[2*(p%16)+k];
            if (off == 'h20 + 4 * (p / 32) && mask[p%32]) m_sync[p] = d[p%32];
        end
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r;
        int off;
        r = 32'd0;
        if (a[31:8] != BASE[31:8]) return r;
        off = int'(a[7:0]) & 'hFC;
        for (int p = 0; p < NP; p++) begin
            if (off == 4 * (p / 16)) r[2*(p%16) +: 2] = m_sel[p];
            if (off == 'h20 + 4 * (p / 32)) r[p%32] = m_sync[p];
        end
        if (off == 'h30) r[0] = m_lock;
        return r;
    endfunction

    // Pad expectations assume io_in has been stable for at least two edges.
    task automatic check_pads(input string tag);
        logic [NP-1:0]    eo, eb;
        logic [NP*NF-1:0] ei;
        int s;
        eo = '0;
        eb = '1;
        ei = '0;
        for (int p = 0; p < NP; p++) begin
            s = int'(m_sel[p]);
            if (s < NF) begin
                eo[p]        = p_out[p*NF+s];
                eb[p]        = ~p_oe[p*NF+s];
                ei[p*NF+s]   = io_in[p];
            end
        end
        chk({tag, "_io_out"}, io_out, eo);
        chk({tag, "_io_oeb"}, io_oeb, eb);
        chk({tag, "_periph_in"}, p_in, ei);
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd);
        int n;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_w && n < 8);
        chk("ack_latency", n, 1);
        rd = dat_w;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("ack_width", ack_w, 0);
        chk("dat_idle", dat_w, 0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        xfer(1'b1, a, d, s, rd);
        if (tgt == 0) m_write(a, d, s);
    endtask

    task automatic rd_val(input logic [31:0] a, output logic [31:0] rd);
        xfer(1'b0, a, 32'd0, 4'hF, rd);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a);
        logic [31:0] rd;
        rd_val(a, rd);
        chk(tag, rd, m_read(a));
    endtask

    task automatic rd_all(input string tag);
        rd_chk({tag, "_sel0"}, BASE + 32'h00);
        rd_chk({tag, "_sel1"}, BASE + 32'h04);
        rd_chk({tag, "_sel2"}, BASE + 32'h08);
        rd_chk({tag, "_sel3"}, BASE + 32'h0C);
        rd_chk({tag, "_sync0"}, BASE + 32'h20);
        rd_chk({tag, "_sync1"}, BASE + 32'h24);
        rd_chk({tag, "_lock"}, BASE + 32'h30);
    endtask

    task automatic rand_pads();
        for (int i = 0; i < NP*NF; i++) begin
            p_out[i] = 1'($urandom_range(0, 1));
            p_oe[i]  = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < NP; i++) io_in[i] = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0, 1, 2, 3: a = BASE + 32'(4 * k);
            4:          a = BASE + 32'h20;
            5:          a = BASE + 32'h24;
            6:          a = BASE + 32'h30;
            7:          a = BASE + 32'(4 * $urandom_range(0, 63));
            8: begin
                a = $urandom;
                a[31:24] = 8'hA5;
            end
            default:    a = BASE + 32'h10;
        endcase
        return a;
    endfunction

    task automatic rand_phase(input int iters, input logic allow_lock);
        logic [31:0] a, d;
        logic [3:0]  s;
        for (int it = 0; it < iters; it++) begin
            a = rand_addr();
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if (!allow_lock && a[7:2] == 6'd12) d[0] = 1'b0;
            if ($urandom_range(0, 1) == 1) wr(a, d, s);
            else rd_chk("rand_rd", a);
            rand_pads();
            repeat (3) @(negedge clk);
            check_pads("rand");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int cnt;

        // Reset defaults
        rand_pads();
        m_reset();
        #1;
        chk("rst_ack0", bus0.wbs_ack_o, 0);
        chk("rst_dat0", bus0.wbs_dat_o, 0);
        chk("rst_ack1", bus1.wbs_ack_o, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_pads("reset");
        rd_all("reset");
        rd_val(BASE + 32'h24, rd);
        chk("reset_sync1_const", rd, 32'h0000_001F);
        rd_val(BASE + 32'h20, rd);
        chk("reset_sync0_const", rd, 32'hFFFF_FFFF);

        // Pad1 to function 2 through byte lane 0
        p_out[6] = 1'b1;
        p_oe[6]  = 1'b1;
        wr(BASE, 32'h0000_0008, 4'b0001);
        chk("pad1_out", io_out[1], 1);
        chk("pad1_oeb", io_oeb[1], 0);
        rd_val(BASE, rd);
        chk("sel0_readback", rd, 32'h0000_0008);
        check_pads("pad1");

        // Pad5 function 1, synchronised then combinational input
        wr(BASE, 32'h0000_0400, 4'b0010);
        io_in[5] = 1'b0;
        repeat (3) @(negedge clk);
        io_in[5] = 1'b1;
        #1 chk("sync_edge0", p_in[21], 0);
        @(negedge clk);
        chk("sync_edge1", p_in[21], 0);
        @(negedge clk);
        chk("sync_edge2", p_in[21], 1);
        chk("sync_others", {p_in[23:22], p_in[20]}, 0);
        wr(BASE + 32'h20, 32'hFFFF_FFDF, 4'hF);
        @(negedge clk);
        io_in[5] = 1'b0;
        #1 chk("comb_fall", p_in[21], 0);
        io_in[5] = 1'b1;
        #1 chk("comb_rise", p_in[21], 1);
        chk("comb_others", {p_in[23:22], p_in[20]}, 0);

        rand_phase(80, 1'b0);

        // Base miss and unmapped offset
        wr(32'h3100_0000, 32'hFFFF_FFFF, 4'hF);
        rd_val(32'h3100_0000, rd);
        chk("miss_rd_zero", rd, 0);
        wr(BASE + 32'h3C, 32'hFFFF_FFFF, 4'hF);
        rd_val(BASE + 32'h3C, rd);
        chk("unmapped_rd_zero", rd, 0);
        rd_all("after_miss");

        // Request held across its ack cycle, then held across two accesses
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ack_w) cnt++;
            if (c == 1) begin stb = 1'b0; cyc = 1'b0; end
        end
        chk("held_one_ack", cnt, 1);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ack_w) cnt++;
            if (c == 3) begin stb = 1'b0; cyc = 1'b0; end
        end
        chk("b2b_two_acks", cnt, 2);

        // Lock
        wr(BASE + 32'h30, 32'h1, 4'b0001);
        rd_val(BASE + 32'h30, rd);
        chk("lock_set", rd, 1);
        wr(BASE + 32'h04, 32'hFFFF_FFFF, 4'hF);
        rd_chk("locked_sel1", BASE + 32'h04);
        wr(BASE + 32'h30, 32'h0, 4'hF);
        rd_val(BASE + 32'h30, rd);
        chk("lock_sticky", rd, 1);
        rand_phase(30, 1'b1);

        // Reset in the middle of a write ack
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE; dat = 32'hFFFF_FFFF; sel = 4'hF;
        @(posedge clk);
        #1 chk("mid_ack_high", bus0.wbs_ack_o, 1);
        rst = 1'b1;
        #1 chk("mid_ack_drop", bus0.wbs_ack_o, 0);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_val(BASE + 32'h30, rd);
        chk("lock_cleared", rd, 0);
        rd_all("after_rst");

        // Three-function instance: select 3 disables the pad
        tgt   = 1;
        s_out = '1;
        s_oe  = '1;
        wr(BASE, 32'h0000_000B, 4'hF);
        rd_val(BASE, rd);
        chk("small_sel0", rd, 32'h0000_000B);
        for (int v = 0; v < 2; v++) begin
            s_io_in[0] = 1'(v);
            s_io_in[1] = 1'(v);
            repeat (3) @(negedge clk);
            chk("dis_out", s_io_out[0], 0);
            chk("dis_oeb", s_io_oeb[0], 1);
            chk("dis_pin", s_pin[2:0], 0);
            chk("f2_out", s_io_out[1], 1);
            chk("f2_oeb", s_io_oeb[1], 0);
            chk("f2_pin", s_pin[5:3], (v == 1) ? 3'b100 : 3'b000);
        end
        wr(BASE, 32'hFFFF_FFFF, 4'hF);
        rd_val(BASE, rd);
        chk("small_sel0_width", rd, 32'h0000_FFFF);
        rd_val(BASE + 32'h20, rd);
        chk("small_sync0", rd, 32'h0000_00FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
